// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Copies PROG_WORDS instruction words from a synchronous boot ROM into the
// instruction-memory write port. It holds the processor in reset during the
// copy and for RST_HOLD cycles after the last write, then releases it. A
// reload pulse while the processor runs restarts the whole sequence.
//
// Sequence after reset release (cycle C0):
//   Cn      rom_addr = n                        (n < PROG_WORDS)
//   C(n+1)  imem_we = 1, imem_addr = 4n, imem_wdata = rom_data
//   then    RST_HOLD cycles with proc_rst still high
//   then    proc_rst = 0, done = 1 until reset or reload
//
// Optional feature (macro IMEM_BOOT_LOADER_CHECKSUM_EN):
//   Each written word is summed modulo 2**DATA_WIDTH. On entry to RUN,
//   checksum_err is set to (sum != EXPECTED_SUM) and held until reset or
//   reload. The processor is released whatever the checksum result is.
//   Without the macro, checksum_err is tied low.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   reload        in   single-cycle restart request, honoured only in RUN
//   rom_addr      out  boot ROM word address (registered)
//   rom_data      in   ROM read data, valid one cycle after rom_addr
//   imem_we       out  instruction-memory write enable (registered)
//   imem_addr     out  instruction-memory byte address (registered)
//   imem_wdata    out  write data, combinational pass-through of rom_data
//   proc_rst      out  active-high reset for the processor (registered)
//   done          out  high while the processor runs (registered)
//   checksum_err  out  load checksum mismatch flag (registered)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    PROG_WORDS   = 16,
    parameter int                    RST_HOLD     = 2,
    parameter int                    ROM_AW       = 8,
    parameter logic [DATA_WIDTH-1:0] EXPECTED_SUM = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reload,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  proc_rst,
    output logic                  done,
    output logic                  checksum_err
);

    // Counters are wide enough to hold PROG_WORDS / RST_HOLD themselves.
    localparam int CNT_W = (PROG_WORDS > 0) ? $clog2(PROG_WORDS + 1) : 1;
    localparam int HLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    localparam logic [CNT_W-1:0] PROG_C      = CNT_W'(PROG_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(32'd1);
    localparam logic [HLD_W-1:0] HLD_ONE_C   = HLD_W'(32'd1);
    localparam logic [HLD_W-1:0] HOLD_LAST_C = HLD_W'((RST_HOLD > 0) ? (RST_HOLD - 1) : 0);
    localparam logic             HOLD_EN_C   = (RST_HOLD > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                  state_q,     state_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [HLD_W-1:0]        hold_cnt_q,  hold_cnt_d;
    logic [ROM_AW-1:0]       rom_addr_q,  rom_addr_d;
    logic                    imem_we_q,   imem_we_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic                    proc_rst_q,  proc_rst_d;
    logic                    done_q,      done_d;

    logic [CNT_W-1:0]        issue_next_s;
    logic                    restart_s;
    logic                    run_entry_s;

    // Next-state and registered-output logic of the load sequencer.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        rom_addr_d   = rom_addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        proc_rst_d   = proc_rst_q;
        done_d       = done_q;
        run_entry_s  = 1'b0;
        issue_next_s = issue_cnt_q + CNT_ONE_C;
        restart_s    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // The counter stops at PROG_WORDS, so "!=" means "more to issue".
                if (issue_cnt_q != PROG_C) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = ADDR_WIDTH'({issue_cnt_q, 2'b00});
                    issue_cnt_d = issue_next_s;
                    // rom_addr parks on the last word instead of running past it.
                    if (issue_next_s != PROG_C) begin
                        rom_addr_d = ROM_AW'(issue_next_s);
                    end else begin
                        rom_addr_d = rom_addr_q;
                    end
                end else if (HOLD_EN_C) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = {HLD_W{1'b0}};
                end else begin
                    state_d     = ST_RUN;
                    proc_rst_d  = 1'b0;
                    done_d      = 1'b1;
                    run_entry_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST_C) begin
                    state_d     = ST_RUN;
                    proc_rst_d  = 1'b0;
                    done_d      = 1'b1;
                    run_entry_s = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HLD_ONE_C;
                end
            end
            ST_RUN: begin
                restart_s = reload;
            end
            default: begin
                // Unreachable encoding: recover by restarting the load.
                restart_s = 1'b1;
            end
        endcase

        // A restart looks exactly like a reset to everything downstream.
        if (restart_s) begin
            state_d     = ST_LOAD;
            issue_cnt_d = {CNT_W{1'b0}};
            hold_cnt_d  = {HLD_W{1'b0}};
            rom_addr_d  = {ROM_AW{1'b0}};
            imem_we_d   = 1'b0;
            imem_addr_d = {ADDR_WIDTH{1'b0}};
            proc_rst_d  = 1'b1;
            done_d      = 1'b0;
            run_entry_s = 1'b0;
        end else begin
            run_entry_s = run_entry_s;
        end
    end

    // State and output registers of the load sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            issue_cnt_q <= {CNT_W{1'b0}};
            hold_cnt_q  <= {HLD_W{1'b0}};
            rom_addr_q  <= {ROM_AW{1'b0}};
            imem_we_q   <= 1'b0;
            imem_addr_q <= {ADDR_WIDTH{1'b0}};
            proc_rst_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rom_addr_q  <= rom_addr_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            proc_rst_q  <= proc_rst_d;
            done_q      <= done_d;
        end
    end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] sum_acc_s;
    logic                  checksum_err_q, checksum_err_d;

    // Checksum accumulation; the word written this cycle is included in
    // the comparison so a RUN entry on the last write sees the full sum.
    always_comb begin
        if (imem_we_q) begin
            sum_acc_s = sum_q + rom_data;
        end else begin
            sum_acc_s = sum_q;
        end
        sum_d          = sum_acc_s;
        checksum_err_d = checksum_err_q;
        if (restart_s) begin
            sum_d          = {DATA_WIDTH{1'b0}};
            checksum_err_d = 1'b0;
        end else if (run_entry_s) begin
            checksum_err_d = (sum_acc_s != EXPECTED_SUM);
        end else begin
            checksum_err_d = checksum_err_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q          <= {DATA_WIDTH{1'b0}};
            checksum_err_q <= 1'b0;
        end else begin
            sum_q          <= sum_d;
            checksum_err_q <= checksum_err_d;
        end
    end

    assign checksum_err = checksum_err_q;
`else
    // Without the checksum feature the reference value and the RUN-entry
    // strobe have no consumer.
    logic unused_s;
    assign unused_s     = ^{EXPECTED_SUM, run_entry_s};
    assign checksum_err = 1'b0;
`endif

    assign rom_addr   = rom_addr_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = rom_data;
    assign proc_rst   = proc_rst_q;
    assign done       = done_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Three loader instances share rst/reload:
//   A: PROG_WORDS=4, RST_HOLD=2, EXPECTED_SUM=10
//   B: PROG_WORDS=0, RST_HOLD=0
//   C: PROG_WORDS=4, RST_HOLD=0, EXPECTED_SUM=11
// The reference model tracks only k = cycles since the last restart and
// derives every expected output from the timeline rules:
//   write in cycle k for 1 <= k <= P (addr 4(k-1), data ROM[k-1]),
//   rom_addr = min(k, P-1), RUN from k = P+H+1 onward.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int PA = 4;
    localparam int HA = 2;
    localparam int PB = 0;
    localparam int HB = 0;
    localparam int PC = 4;
    localparam int HC = 0;
    localparam logic [31:0] EA = 32'd10;
    localparam logic [31:0] EB = 32'd0;
    localparam logic [31:0] EC = 32'd11;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [31:0] rom_t [16];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reload = 1'b0;

    always #5 clk = ~clk;

    rom_t rom_a;
    rom_t rom_b;
    rom_t rom_c;

    logic [3:0]  ra_a, ra_b, ra_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        we_a, we_b, we_c;
    logic [31:0] ad_a, ad_b, ad_c;
    logic [31:0] wd_a, wd_b, wd_c;
    logic        pr_a, pr_b, pr_c;
    logic        dn_a, dn_b, dn_c;
    logic        er_a, er_b, er_c;

    // Synchronous boot ROMs.
    always @(posedge clk) begin
        rd_a <= rom_a[ra_a];
        rd_b <= rom_b[ra_b];
        rd_c <= rom_c[ra_c];
    end

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PROG_WORDS(PA), .RST_HOLD(HA),
                       .ROM_AW(4), .EXPECTED_SUM(EA)) dut (
        .clk(clk), .rst(rst), .reload(reload), .rom_addr(ra_a), .rom_data(rd_a),
        .imem_we(we_a), .imem_addr(ad_a), .imem_wdata(wd_a), .proc_rst(pr_a),
        .done(dn_a), .checksum_err(er_a));

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PROG_WORDS(PB), .RST_HOLD(HB),
                       .ROM_AW(4), .EXPECTED_SUM(EB)) dut_b (
        .clk(clk), .rst(rst), .reload(reload), .rom_addr(ra_b), .rom_data(rd_b),
        .imem_we(we_b), .imem_addr(ad_b), .imem_wdata(wd_b), .proc_rst(pr_b),
        .done(dn_b), .checksum_err(er_b));

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PROG_WORDS(PC), .RST_HOLD(HC),
                       .ROM_AW(4), .EXPECTED_SUM(EC)) dut_c (
        .clk(clk), .rst(rst), .reload(reload), .rom_addr(ra_c), .rom_data(rd_c),
        .imem_we(we_c), .imem_addr(ad_c), .imem_wdata(wd_c), .proc_rst(pr_c),
        .done(dn_c), .checksum_err(er_c));

    int total = 0;
    int bad   = 0;
    int ka = 0;
    int kb = 0;
    int kc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rom_sum(input rom_t r, input int p);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < p; i++) s = s + r[i];
        return s;
    endfunction

    task automatic check_dut(input string nm, input int p, input int h, input int k,
                             input rom_t r, input logic [31:0] es,
                             input logic [3:0] ra, input logic we, input logic [31:0] ad,
                             input logic [31:0] wd, input logic pr, input logic dn,
                             input logic er);
        bit run;
        bit exp_we;
        int exp_ra;
        bit exp_err;
        run     = (k >= p + h + 1);
        exp_we  = (k >= 1) && (k <= p);
        exp_ra  = (p == 0) ? 0 : ((k < p) ? k : p - 1);
        exp_err = CHK_EN && run && (rom_sum(r, p) != es);
        chk({nm, ".imem_we k=", $sformatf("%0d", k)}, 32'(we), 32'(exp_we));
        chk({nm, ".rom_addr"}, 32'(ra), 32'(exp_ra));
        chk({nm, ".proc_rst"}, 32'(pr), 32'(!run));
        chk({nm, ".done"}, 32'(dn), 32'(run));
        chk({nm, ".checksum_err"}, 32'(er), 32'(exp_err));
        chk({nm, ".we_implies_rst"}, 32'(we & ~pr), 32'd0);
        chk({nm, ".done_not_rst"}, 32'(dn ^ pr), 32'd1);
        if (exp_we) begin
            chk({nm, ".imem_addr"}, ad, 32'(4 * (k - 1)));
            chk({nm, ".imem_wdata"}, wd, r[k - 1]);
        end
        if (k == 0) begin
            chk({nm, ".imem_addr_rst"}, ad, 32'd0);
        end
    endtask

    function automatic int next_k(input int k, input int p, input int h,
                                  input logic r, input logic rl);
        if (r || (rl && (k >= p + h + 1))) return 0;
        if (k < 100000) return k + 1;
        return k;
    endfunction

    // One clock with the given rst/reload, then model update and checks.
    task automatic step(input logic r, input logic rl);
        rst    = r;
        reload = rl;
        @(posedge clk);
        ka = next_k(ka, PA, HA, r, rl);
        kb = next_k(kb, PB, HB, r, rl);
        kc = next_k(kc, PC, HC, r, rl);
        @(negedge clk);
        check_dut("A", PA, HA, ka, rom_a, EA, ra_a, we_a, ad_a, wd_a, pr_a, dn_a, er_a);
        check_dut("B", PB, HB, kb, rom_b, EB, ra_b, we_b, ad_b, wd_b, pr_b, dn_b, er_b);
        check_dut("C", PC, HC, kc, rom_c, EC, ra_c, we_c, ad_c, wd_c, pr_c, dn_c, er_c);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = 32'h2008_0000 + 32'(i);
            rom_b[i] = $urandom;
            rom_c[i] = (i < 4) ? 32'(i + 1) : $urandom;
        end

        // Basic load: reset two cycles, then the full sequence.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run_idle(12);

        // Reset during the third cycle of a load.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_idle(10);

        // Reload while running.
        step(1'b0, 1'b1);
        run_idle(10);

        // Reload while A is in HOLD (B and C already run).
        step(1'b1, 1'b0);
        run_idle(5);
        step(1'b0, 1'b1);
        run_idle(10);

        // Checksum case: ROM {1,2,3,4} gives sum 10.
        for (int i = 0; i < 4; i++) rom_a[i] = 32'(i + 1);
        step(1'b1, 1'b0);
        run_idle(10);

        // Randomized ROM contents with random reset and reload pulses.
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic rl;
            r  = ($urandom_range(0, 29) == 0);
            rl = ($urandom_range(0, 5) == 0);
            if (r) begin
                for (int i = 0; i < 16; i++) begin
                    rom_a[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
                    rom_c[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
                end
            end
            step(r, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
